// File: rtl/stim_sweeper.sv
// rtl/stim_sweeper.sv - self-running exhaustive stimulus sequencer with valid/ready record capture
// Walks every input vector (TABLE) or every ordered low->high pair (TRANSITION) and streams responses.
module stim_sweeper #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [N_IN-1:0]  cap_vec,
    output logic [N_OUT-1:0] cap_resp,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [N_IN-1:0] VMAX  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] ONE   = N_IN'(1);
    localparam logic [CW-1:0]   CLAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

    state_t          state;
    logic            mode_r;
    logic [N_IN-1:0] vi;
    logic [N_IN-1:0] vj;
    logic            phase;
    logic [CW-1:0]   cnt;

    logic            last_step;
    logic [N_IN-1:0] nxt_i;
    logic [N_IN-1:0] nxt_j;
    logic            nxt_phase;
    logic [N_IN-1:0] nxt_vec;

    // TABLE uses vi alone; TRANSITION emits vi (phase 0) then vj (phase 1) for each pair.
    always_comb begin
        last_step = 1'b0;
        nxt_i     = vi;
        nxt_j     = vj;
        nxt_phase = 1'b0;
        nxt_vec   = vi;
        if (!mode_r) begin
            last_step = (vi == VMAX);
            nxt_i     = vi + ONE;
            nxt_vec   = vi + ONE;
        end else if (!phase) begin
            nxt_phase = 1'b1;
            nxt_vec   = vj;
        end else if (vi == VMAX - ONE) begin
            last_step = 1'b1;
        end else if (vj == VMAX) begin
            nxt_i   = vi + ONE;
            nxt_j   = vi + ONE + ONE;
            nxt_vec = vi + ONE;
        end else begin
            nxt_j   = vj + ONE;
            nxt_vec = vi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            vi        <= '0;
            vj        <= '0;
            phase     <= 1'b0;
            cnt       <= '0;
            dut_in    <= '0;
            cap_valid <= 1'b0;
            cap_vec   <= '0;
            cap_resp  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Pending record is dropped; no done pulse for an aborted sweep.
            state     <= IDLE;
            dut_in    <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        vi     <= '0;
                        vj     <= ONE;
                        phase  <= 1'b0;
                        dut_in <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CLAST) begin
                        cap_vec   <= dut_in;
                        cap_resp  <= dut_out;
                        cap_valid <= 1'b1;
                        state     <= CAPTURE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CAPTURE: begin
                    if (cap_valid && cap_ready) begin
                        cap_valid <= 1'b0;
                        if (last_step) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            vi     <= nxt_i;
                            vj     <= nxt_j;
                            phase  <= nxt_phase;
                            dut_in <= nxt_vec;
                            cnt    <= '0;
                            state  <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    dut_in <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
